// File: rtl/fetch_stage_if.sv
// fetch_stage_if
//   Bundles the control, program-load and IF/ID output signals of the
//   instruction-fetch stage. clk and rst_n stay plain ports on the stage.
//
//   Signals:
//     stall          hold PC and IF/ID this cycle
//     branch_taken   redirect fetch to branch_target and flush IF/ID
//     branch_target  redirect byte address (low two bits ignored, flagged)
//     imem_we        program-load write enable
//     imem_waddr     program-load word index
//     imem_wdata     program-load data word
//     if_id_instr    registered instruction
//     if_id_pc       PC of if_id_instr
//     if_id_valid    if_id_instr is a real fetched instruction
//     opcode         if_id_instr[6:0]
//     pc             current fetch PC
//     fetch_fault    sticky out-of-range / misaligned-target flag
//
//   Handshake: there is no backpressure from decode. A word on if_id_instr
//   is meaningful exactly when if_id_valid is high; while stall is high the
//   IF/ID contents (including if_id_valid) are held unchanged, and a
//   branch_taken cycle always produces a bubble (if_id_valid low).
//
//   Modports: slave = the fetch stage, master = whoever drives it.
interface fetch_stage_if #(
    parameter int IMEM_DEPTH = 64
);
    localparam int AW = $clog2(IMEM_DEPTH);

    logic          stall;
    logic          branch_taken;
    logic [31:0]   branch_target;
    logic          imem_we;
    logic [AW-1:0] imem_waddr;
    logic [31:0]   imem_wdata;
    logic [31:0]   if_id_instr;
    logic [31:0]   if_id_pc;
    logic          if_id_valid;
    logic [6:0]    opcode;
    logic [31:0]   pc;
    logic          fetch_fault;

    modport slave (
        input  stall, branch_taken, branch_target,
        input  imem_we, imem_waddr, imem_wdata,
        output if_id_instr, if_id_pc, if_id_valid, opcode, pc, fetch_fault
    );

    modport master (
        output stall, branch_taken, branch_target,
        output imem_we, imem_waddr, imem_wdata,
        input  if_id_instr, if_id_pc, if_id_valid, opcode, pc, fetch_fault
    );
endinterface

// File: rtl/fetch_stage.sv
// fetch_stage
//   Instruction-fetch stage: program counter, word-addressed instruction
//   memory with a program-load write port, and the IF/ID pipeline register.
//
//   Ports:
//     clk    rising-edge clock
//     rst_n  synchronous active-low reset
//     bus    fetch_stage_if.slave (control inputs, load port, IF/ID outputs)
//
//   Parameters:
//     IMEM_DEPTH  memory depth in 32-bit words (power of two, 4..4096)
//     RESET_PC    word-aligned PC loaded on reset
module fetch_stage #(
    parameter int          IMEM_DEPTH = 64,
    parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    fetch_stage_if.slave    bus
);
    localparam int          AW  = $clog2(IMEM_DEPTH);
    localparam logic [31:0] NOP = 32'h0000_0013;

    logic [31:0]   mem [IMEM_DEPTH];

    logic [31:0]   pcQ;
    logic [31:0]   instrQ;
    logic [31:0]   instrPcQ;
    logic          validQ;
    logic          faultQ;

    logic [AW-1:0] pcIdx;
    logic          pcInRange;
    logic [31:0]   fetchWord;
    logic          targetMisaligned;

    // Any PC bit above the word index means the fetch is past the memory.
    assign pcIdx            = pcQ[AW+1:2];
    assign pcInRange        = (pcQ[31:AW+2] == '0);
    assign fetchWord        = pcInRange ? mem[pcIdx] : NOP;
    assign targetMisaligned = (bus.branch_target[1:0] != 2'b00);

    // Program-load port. The combinational read above sees the pre-edge
    // contents, so a same-cycle write/fetch to one word returns old data.
    // No write happens while reset is asserted; memory is never cleared.
    always_ff @(posedge clk) begin
        if (rst_n && bus.imem_we) begin
            mem[bus.imem_waddr] <= bus.imem_wdata;
        end
    end

    // PC and IF/ID register. Branch wins over stall; stall freezes
    // everything including the fault flag update from a fetch.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pcQ      <= RESET_PC;
            instrQ   <= NOP;
            instrPcQ <= 32'h0;
            validQ   <= 1'b0;
            faultQ   <= 1'b0;
        end else if (bus.branch_taken) begin
            pcQ      <= {bus.branch_target[31:2], 2'b00};
            instrQ   <= NOP;
            instrPcQ <= 32'h0;
            validQ   <= 1'b0;
            if (targetMisaligned) begin
                faultQ <= 1'b1;
            end
        end else if (!bus.stall) begin
            pcQ      <= pcQ + 32'd4;
            instrQ   <= fetchWord;
            instrPcQ <= pcQ;
            validQ   <= 1'b1;
            if (!pcInRange) begin
                faultQ <= 1'b1;
            end
        end
    end

    assign bus.if_id_instr = instrQ;
    assign bus.if_id_pc    = instrPcQ;
    assign bus.if_id_valid = validQ;
    assign bus.opcode      = instrQ[6:0];
    assign bus.pc          = pcQ;
    assign bus.fetch_fault = faultQ;
endmodule

// File: tb/tb_fetch_stage.sv
module tb_fetch_stage;
    localparam int          DEPTH = 64;
    localparam int          AW    = 6;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    fetch_stage_if #(.IMEM_DEPTH(DEPTH)) bus ();

    fetch_stage #(.IMEM_DEPTH(DEPTH), .RESET_PC(32'h0000_0000)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // ---------------- reference model + scoreboard ----------------
    // exp_q entry: {instr[31:0], pc[31:0], valid}
    logic [64:0] expQ[$];
    logic [31:0] mMem [DEPTH];
    logic [31:0] mPc;
    logic        mFault;
    logic [64:0] mHeld;

    int nCmp = 0;
    int nErr = 0;

    task automatic checkEq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nCmp++;
        if (got !== exp) begin
            nErr++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // One clock cycle with rst_n high: drive, predict, push, then pop/compare.
    task automatic step(input logic st, input logic br, input logic [31:0] tgt,
                        input logic we, input logic [AW-1:0] wa, input logic [31:0] wd);
        logic [64:0] e;
        logic [64:0] got;
        @(negedge clk);
        rst_n             = 1'b1;
        bus.stall         = st;
        bus.branch_taken  = br;
        bus.branch_target = tgt;
        bus.imem_we       = we;
        bus.imem_waddr    = wa;
        bus.imem_wdata    = wd;
        if (br) begin
            e = {NOP, 32'h0, 1'b0};
            if (tgt[1:0] != 2'b00) mFault = 1'b1;
            mPc = {tgt[31:2], 2'b00};
        end else if (!st) begin
            if (mPc < 32'd256) begin
                e = {mMem[mPc[7:2]], mPc, 1'b1};
            end else begin
                e = {NOP, mPc, 1'b1};
                mFault = 1'b1;
            end
            mPc = mPc + 32'd4;
        end else begin
            e = mHeld;
        end
        mHeld = e;
        if (we) mMem[wa] = wd;   // after the read: old data wins on collision
        expQ.push_back(e);
        @(posedge clk);
        #1;
        got = expQ.pop_front();
        checkEq("instr",  bus.if_id_instr, got[64:33]);
        checkEq("if_pc",  bus.if_id_pc,    got[32:1]);
        checkEq("valid",  {31'b0, bus.if_id_valid}, {31'b0, got[0]});
        checkEq("opcode", {25'b0, bus.opcode}, {25'b0, got[39:33]});
        checkEq("pc",     bus.pc, mPc);
        checkEq("fault",  {31'b0, bus.fetch_fault}, {31'b0, mFault});
    endtask

    // One clock cycle with rst_n low and arbitrary other inputs.
    task automatic doReset(input logic st, input logic we, input logic [AW-1:0] wa, input logic [31:0] wd);
        @(negedge clk);
        rst_n             = 1'b0;
        bus.stall         = st;
        bus.branch_taken  = 1'b1;
        bus.branch_target = 32'h0000_0042;
        bus.imem_we       = we;
        bus.imem_waddr    = wa;
        bus.imem_wdata    = wd;
        mPc    = 32'h0;
        mFault = 1'b0;
        mHeld  = {NOP, 32'h0, 1'b0};
        @(posedge clk);
        #1;
        checkEq("rst_pc",    bus.pc, 32'h0);
        checkEq("rst_instr", bus.if_id_instr, NOP);
        checkEq("rst_ifpc",  bus.if_id_pc, 32'h0);
        checkEq("rst_valid", {31'b0, bus.if_id_valid}, 32'h0);
        checkEq("rst_fault", {31'b0, bus.fetch_fault}, 32'h0);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] prog [4];
        prog[0] = 32'h0050_0093;
        prog[1] = 32'h00A0_0113;
        prog[2] = 32'h0020_81B3;
        prog[3] = 32'h0000_A203;

        rst_n = 1'b0;
        bus.stall = 1'b0; bus.branch_taken = 1'b0; bus.branch_target = 32'h0;
        bus.imem_we = 1'b0; bus.imem_waddr = '0; bus.imem_wdata = 32'h0;
        for (int i = 0; i < DEPTH; i++) mMem[i] = 32'hx;

        doReset(1'b0, 1'b0, '0, 32'h0);
        doReset(1'b0, 1'b0, '0, 32'h0);

        // Program load while stalled so no fetch of unloaded words happens.
        for (int i = 0; i < DEPTH; i++) begin
            step(1'b1, 1'b0, 32'h0, 1'b1, AW'(i), (i < 4) ? prog[i] : $urandom());
        end
        doReset(1'b0, 1'b0, '0, 32'h0);

        // Sequencing and stall at pc=8
        step(1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        checkEq("seq0", bus.if_id_instr, 32'h0050_0093);
        checkEq("seq0_op", {25'b0, bus.opcode}, 32'h13);
        step(1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        checkEq("seq1", bus.if_id_instr, 32'h00A0_0113);
        for (int i = 0; i < 3; i++) step(1'b1, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        checkEq("stall_ifpc", bus.if_id_pc, 32'h4);
        checkEq("stall_pc", bus.pc, 32'h8);
        step(1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        checkEq("seq2_op", {25'b0, bus.opcode}, 32'h33);

        // Branch with simultaneous stall at pc=12
        step(1'b1, 1'b1, 32'h20, 1'b0, '0, 32'h0);
        checkEq("br_pc", bus.pc, 32'h20);
        step(1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        checkEq("br_tgt_ifpc", bus.if_id_pc, 32'h20);

        // Misaligned target, then out-of-range fetch
        step(1'b0, 1'b1, 32'h22, 1'b0, '0, 32'h0);
        checkEq("mis_pc", bus.pc, 32'h20);
        checkEq("mis_fault", {31'b0, bus.fetch_fault}, 32'h1);
        step(1'b0, 1'b1, 32'h100, 1'b0, '0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        checkEq("oor_instr", bus.if_id_instr, NOP);
        step(1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0);

        // Write/fetch collision at pc=8
        step(1'b0, 1'b1, 32'h0, 1'b1, AW'(2), 32'h1111_1111);
        step(1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b1, AW'(2), 32'h2222_2222);
        checkEq("coll_old", bus.if_id_instr, 32'h1111_1111);
        step(1'b0, 1'b1, 32'h8, 1'b0, '0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        checkEq("coll_new", bus.if_id_instr, 32'h2222_2222);

        // Reset mid-run with stall and write asserted: word 3 must survive
        doReset(1'b1, 1'b1, AW'(3), 32'hDEAD_BEEF);
        step(1'b0, 1'b1, 32'hC, 1'b0, '0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        checkEq("rst_nowrite", bus.if_id_instr, 32'h0000_A203);

        // PC wrap
        step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, '0, 32'h0);
        step(1'b0, 1'b0, 32'h0, 1'b0, '0, 32'h0);
        checkEq("wrap_pc", bus.pc, 32'h0);
        doReset(1'b0, 1'b0, '0, 32'h0);

        // Random traffic
        for (int i = 0; i < 300; i++) begin
            logic        st;
            logic        br;
            logic [31:0] tgt;
            st  = ($urandom_range(0, 3) == 0);
            br  = ($urandom_range(0, 9) == 0);
            tgt = ($urandom_range(0, 7) == 0) ? $urandom() : {$urandom_range(0, 80), 2'b00};
            if ($urandom_range(0, 5) == 0) tgt[1:0] = 2'($urandom_range(1, 3));
            step(st, br, tgt, ($urandom_range(0, 2) == 0), AW'($urandom_range(0, DEPTH - 1)), $urandom());
            if ($urandom_range(0, 60) == 0) doReset(1'($urandom_range(0, 1)), 1'b1, AW'($urandom_range(0, DEPTH - 1)), $urandom());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nErr);
        $finish;
    end
endmodule

// File: doc/fetch_stage.md
# fetch_stage

Instruction-fetch stage of the RISC-V datapath: holds the program counter, reads a word-addressed instruction memory, and registers the fetched word into the IF/ID pipeline register. Its `opcode` output drives the main control decoder; the branch-redirect inputs come from the branch-resolution logic downstream. The block also provides a program-load write port used by the testbench and boot logic.

## Interface
- IMEM_DEPTH, 64, instruction memory depth in 32-bit words; power of two, 4..4096
- RESET_PC, 32'h0000_0000, PC value loaded on reset; word-aligned
- clk  in  1  clock; all state updates on rising edge
- rst_n  in  1  reset, synchronous, active-low
- stall  in  1  hold PC and IF/ID contents this cycle
- branch_taken  in  1  redirect fetch to branch_target and flush IF/ID
- branch_target  in  32  redirect address
- imem_we  in  1  program-load write enable
- imem_waddr  in  log2(IMEM_DEPTH)  word index for program load
- imem_wdata  in  32  program-load data
- if_id_instr  out  32  registered instruction
- if_id_pc  out  32  PC of if_id_instr
- if_id_valid  out  1  if_id_instr is a real fetched instruction
- opcode  out  7  if_id_instr[6:0], combinational from the register
- pc  out  32  current fetch PC
- fetch_fault  out  1  sticky: out-of-range fetch or misaligned target seen

## Operation
- Reset (rst_n low at a rising edge): pc = RESET_PC, if_id_instr = 32'h0000_0013 (NOP, addi x0,x0,0), if_id_pc = 0, if_id_valid = 0, fetch_fault = 0. Memory contents are not cleared.
- Normal cycle (no stall, no branch): IF/ID <= {mem[pc index], pc, valid=1}; pc <= pc + 4 (mod 2^32).
- pc index = pc[log2(IMEM_DEPTH)+1:2]. If pc >= 4*IMEM_DEPTH, the fetched word is NOP, valid=1, and fetch_fault is set.
- stall=1, branch_taken=0: pc and all IF/ID outputs hold.
- branch_taken=1 overrides stall: pc <= {branch_target[31:2], 2'b00}; IF/ID <= NOP, if_id_pc=0, valid=0 (flush).
- A branch_target with bits [1:0] != 0 sets fetch_fault; the redirect still proceeds to the aligned address.
- fetch_fault is cleared only by reset.
- Program load: imem_we=1 writes imem_wdata to mem[imem_waddr] at the edge. Loading is independent of stall/branch and of fetch.
- Same-cycle write and fetch to the same word: fetch returns the OLD contents (read-before-write); the new word is visible from the next cycle.

## Timing
- Memory read is combinational from pc; the instruction appears on if_id_instr/opcode one cycle after pc holds its address.
- Fetch-to-decode latency: 1 cycle. Branch penalty: 1 bubble (valid=0) after branch_taken, then the target instruction on the following edge.
- First valid instruction after reset release: if_id_valid=1 at the 1st rising edge with rst_n high, carrying mem[RESET_PC>>2].
- Reset dominates every other input in the same cycle, including imem_we (no write during reset).
- pc = 32'hFFFF_FFFC increments to 32'h0000_0000 (wrap, no fault from the wrap itself).

## Test plan
- Reset/sequencing: load words 0..3 with 0x00500093, 0x00A00113, 0x002081B3, 0x0000A203; release reset -> edges 1..4 show if_id_pc 0,4,8,12, matching instrs, opcode 0x13,0x13,0x33,0x03, valid=1.
- Stall: assert stall for 3 cycles at pc=8 -> if_id_pc stays 4, pc stays 8; after release if_id_pc=8 next edge.
- Branch with simultaneous stall: at pc=12 assert branch_taken and stall, target 0x20 -> next edge pc=0x20, valid=0, instr=0x13; following edge if_id_pc=0x20, valid=1.
- Misaligned and out-of-range: target 0x22 -> pc=0x20, fetch_fault=1; with IMEM_DEPTH=64, branch to 0x100 -> if_id_instr=0x13, valid=1, fault stays 1 until reset.
- Write/fetch collision: mem[2]=0x11111111, write 0x22222222 to index 2 in the cycle pc=8 -> if_id_instr=0x11111111; refetch of pc=8 returns 0x22222222.
- Reset mid-run: assert rst_n=0 while stall=1 and imem_we=1 -> pc=RESET_PC, valid=0, fault=0, memory word unchanged.
